// File: rtl/aes_job_queue_if.sv
// Job, result and core-handshake bundle for aes_job_queue.
// The queue sits on the slave side; producer/consumer/core sit on the master side.
interface aes_job_queue_if #(
  parameter int BLOCK_W = 128,
  parameter int TAG_W   = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_data;
  logic               in_dir;
  logic [TAG_W-1:0]   in_tag;

  logic               core_start;
  logic               core_mode;
  logic [BLOCK_W-1:0] core_key;
  logic [BLOCK_W-1:0] core_data;
  logic               core_done;
  logic [BLOCK_W-1:0] core_result;

  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               out_dir;

  modport slave (
    input  in_valid, in_data, in_dir, in_tag, core_done, core_result, out_ready,
    output in_ready, core_start, core_mode, core_key, core_data,
           out_valid, out_data, out_tag, out_dir
  );

  modport master (
    output in_valid, in_data, in_dir, in_tag, core_done, core_result, out_ready,
    input  in_ready, core_start, core_mode, core_key, core_data,
           out_valid, out_data, out_tag, out_dir
  );
endinterface

// File: rtl/aes_job_queue.sv
// Buffered, tagged AES job front-end: FIFO of jobs, one-at-a-time issue to an
// external round core via start/done, optional CBC chaining, in-order results.
module aes_job_queue #(
  parameter int DEPTH   = 4,
  parameter int BLOCK_W = 128,
  parameter int TAG_W   = 4,
  parameter int CBC_EN  = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_key_load,
  input  logic [BLOCK_W-1:0]           i_key_in,
  input  logic                         i_iv_load,
  input  logic [BLOCK_W-1:0]           i_iv_in,
  output logic                         o_key_err,
  output logic [$clog2(DEPTH+1)-1:0]   o_q_count,
  output logic                         o_busy,
  aes_job_queue_if.slave               bus
);

  localparam int   PW    = $clog2(DEPTH);
  localparam int   CW    = $clog2(DEPTH + 1);
  localparam logic W_CBC = (CBC_EN != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [BLOCK_W-1:0] r_mem_data [DEPTH];
  logic               r_mem_dir  [DEPTH];
  logic [TAG_W-1:0]   r_mem_tag  [DEPTH];

  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      w_count_next;
  logic               r_in_ready;
  logic               r_busy;
  logic               w_push;
  logic               w_pop;
  logic               w_done;
  logic               w_key_acc;
  logic               w_iv_acc;

  logic [BLOCK_W-1:0] r_key;
  logic               r_key_valid;
  logic [BLOCK_W-1:0] r_chain;
  logic               r_key_err;

  logic [BLOCK_W-1:0] r_job_data;
  logic               r_job_dir;
  logic [TAG_W-1:0]   r_job_tag;

  logic               r_core_start;
  logic               r_core_mode;
  logic [BLOCK_W-1:0] r_core_data;

  logic               r_out_valid;
  logic [BLOCK_W-1:0] r_out_data;
  logic [TAG_W-1:0]   r_out_tag;
  logic               r_out_dir;

  assign w_push       = bus.in_valid & r_in_ready;
  assign w_pop        = (r_state == S_IDLE) & (r_count != CW'(0)) & r_key_valid;
  assign w_done       = (r_state == S_WAIT) & bus.core_done;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  // Key/IV may only change while nothing is queued or in flight.
  assign w_key_acc    = i_key_load & ~r_busy;
  assign w_iv_acc     = i_iv_load & ~r_busy;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop) w_state_next = S_ISSUE;
        else       w_state_next = S_IDLE;
      end
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT: begin
        if (bus.core_done) w_state_next = S_HOLD;
        else               w_state_next = S_WAIT;
      end
      S_HOLD: begin
        if (bus.out_ready) w_state_next = S_IDLE;
        else               w_state_next = S_HOLD;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Queue storage carries no reset; only pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= bus.in_data;
      r_mem_dir[r_wptr]  <= bus.in_dir;
      r_mem_tag[r_wptr]  <= bus.in_tag;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next != CW'(DEPTH));
      r_busy     <= (w_state_next != S_IDLE) | (w_count_next != CW'(0));
    end
  end

  // A single rejection pulse covers a simultaneous bad key and IV load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_chain     <= '0;
      r_key_err   <= 1'b0;
    end else begin
      r_key_err <= (i_key_load | i_iv_load) & r_busy;
      if (w_key_acc) begin
        r_key       <= i_key_in;
        r_key_valid <= 1'b1;
      end
      if (w_iv_acc)
        r_chain <= i_iv_in;
      else if (w_done && W_CBC)
        r_chain <= r_job_dir ? bus.core_result : r_job_data;
    end
  end

  // Chain cannot move between pop and core_done, so the core input is fixed at pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_job_data   <= '0;
      r_job_dir    <= 1'b0;
      r_job_tag    <= '0;
      r_core_mode  <= 1'b0;
      r_core_data  <= '0;
      r_core_start <= 1'b0;
    end else begin
      r_core_start <= (w_state_next == S_ISSUE);
      if (w_pop) begin
        r_job_data  <= r_mem_data[r_rptr];
        r_job_dir   <= r_mem_dir[r_rptr];
        r_job_tag   <= r_mem_tag[r_rptr];
        r_core_mode <= r_mem_dir[r_rptr];
        r_core_data <= (W_CBC && r_mem_dir[r_rptr]) ? (r_mem_data[r_rptr] ^ r_chain)
                                                    : r_mem_data[r_rptr];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_out_dir   <= 1'b0;
    end else begin
      r_out_valid <= (w_state_next == S_HOLD);
      if (w_done) begin
        r_out_data <= (W_CBC && !r_job_dir) ? (bus.core_result ^ r_chain) : bus.core_result;
        r_out_tag  <= r_job_tag;
        r_out_dir  <= r_job_dir;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.core_start = r_core_start;
  assign bus.core_mode  = r_core_mode;
  assign bus.core_key   = r_key;
  assign bus.core_data  = r_core_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_tag    = r_out_tag;
  assign bus.out_dir    = r_out_dir;
  assign o_key_err      = r_key_err;
  assign o_q_count      = r_count;
  assign o_busy         = r_busy;

endmodule
